// File: rtl/ctrl_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_pipe -- pipelined control unit for the 5-stage RISC-V core.
//
// Decodes the ID-stage opcode into a control bundle and carries it through
// the ID/EX, EX/MEM and MEM/WB registers with valid bits. It also detects
// RAW hazards, drives the IF/ID stall, applies branch/jump flushes, produces
// EX operand forwarding selects and counts stall cycles.
//
// Build option:
//   CTRL_FORWARD_EN  defined   -> MEM/WB forwarding; only load-use stalls.
//                    undefined -> forwarding tied off; any in-flight writer
//                                 in EX or MEM of a used source stalls.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   id_valid, id_opcode   ID instruction present, instruction[6:0]
//   id_rs1/rs2/rd         ID register indices
//   ex_flush              taken branch/jump resolved in EX
//   stall                 hold PC and IF/ID (combinational)
//   ex_*                  ID/EX bundle and indices
//   mem_*                 EX/MEM bundle
//   wb_*                  MEM/WB bundle
//   forward_a/b           EX operand select: 00 regfile, 10 MEM, 01 WB
//   stall_count           saturating count of cycles with stall=1
// ---------------------------------------------------------------------------
module ctrl_pipe #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [6:0]             id_opcode,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   ex_flush,
  output logic                   stall,
  output logic                   ex_valid,
  output logic                   ex_alu_src,
  output logic                   ex_mem_read,
  output logic                   ex_mem_write,
  output logic                   ex_reg_write,
  output logic [1:0]             ex_alu_op,
  output logic [1:0]             ex_ctrl_transfer,
  output logic [1:0]             ex_wb_data_src,
  output logic [REG_ADDR_W-1:0]  ex_rs1,
  output logic [REG_ADDR_W-1:0]  ex_rs2,
  output logic [REG_ADDR_W-1:0]  ex_rd,
  output logic                   mem_valid,
  output logic                   mem_mem_read,
  output logic                   mem_mem_write,
  output logic                   mem_reg_write,
  output logic [1:0]             mem_wb_data_src,
  output logic [REG_ADDR_W-1:0]  mem_rd,
  output logic                   wb_valid,
  output logic                   wb_reg_write,
  output logic [1:0]             wb_wb_data_src,
  output logic [REG_ADDR_W-1:0]  wb_rd,
  output logic [1:0]             forward_a,
  output logic [1:0]             forward_b,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] ctrl_transfer;
    logic [1:0] wb_data_src;
  } ctrl_t;

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  id_use_rs1;
  logic  id_use_rs2;
  logic  rs1_live;
  logic  rs2_live;
  logic  hazard;
  logic  load_id;

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path through the case leaves it unassigned (inferred latch).
    id_ctrl    = '0;
    id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0;
    case (id_opcode)
      OPC_OP: begin
        id_ctrl.alu_op    = 2'b01;
        id_ctrl.reg_write = 1'b1;
        id_use_rs1        = 1'b1;
        id_use_rs2        = 1'b1;
      end
      OPC_OP_IMM: begin
        id_ctrl.alu_src   = 1'b1;
        id_ctrl.alu_op    = 2'b01;
        id_ctrl.reg_write = 1'b1;
        id_use_rs1        = 1'b1;
      end
      OPC_LOAD: begin
        id_ctrl.alu_src     = 1'b1;
        id_ctrl.mem_read    = 1'b1;
        id_ctrl.wb_data_src = 2'b01;
        id_ctrl.reg_write   = 1'b1;
        id_use_rs1          = 1'b1;
      end
      OPC_STORE: begin
        id_ctrl.alu_src   = 1'b1;
        id_ctrl.mem_write = 1'b1;
        id_use_rs1        = 1'b1;
        id_use_rs2        = 1'b1;
      end
      OPC_BRANCH: begin
        id_ctrl.alu_op        = 2'b10;
        id_ctrl.ctrl_transfer = 2'b01;
        id_use_rs1            = 1'b1;
        id_use_rs2            = 1'b1;
      end
      OPC_JAL: begin
        id_ctrl.ctrl_transfer = 2'b10;
        id_ctrl.wb_data_src   = 2'b10;
        id_ctrl.reg_write     = 1'b1;
      end
      OPC_JALR: begin
        id_ctrl.alu_src       = 1'b1;
        id_ctrl.ctrl_transfer = 2'b11;
        id_ctrl.wb_data_src   = 2'b10;
        id_ctrl.reg_write     = 1'b1;
        id_use_rs1            = 1'b1;
      end
      OPC_LUI: begin
        id_ctrl.alu_src     = 1'b1;
        id_ctrl.alu_op      = 2'b11;
        id_ctrl.wb_data_src = 2'b11;
        id_ctrl.reg_write   = 1'b1;
      end
      default: ;
    endcase
    // x0 is hardwired, so writing it is a no-op rather than a real write.
    if (id_rd == '0) id_ctrl.reg_write = 1'b0;
  end

  // x0 never carries a dependency.
  assign rs1_live = id_use_rs1 && (id_rs1 != '0);
  assign rs2_live = id_use_rs2 && (id_rs2 != '0);

  // ---------------------------------------------------------------------
  // Hazard detection and forwarding
  // ---------------------------------------------------------------------
`ifdef CTRL_FORWARD_EN
  // Only a load in EX cannot be forwarded in time: its data appears in MEM.
  assign hazard = ex_valid && ex_mem_read &&
                  ((rs1_live && (id_rs1 == ex_rd)) ||
                   (rs2_live && (id_rs2 == ex_rd)));

  always_comb begin
    forward_a = 2'b00;
    if (ex_rs1 != '0) begin
      if (mem_valid && mem_reg_write && (mem_rd == ex_rs1))    forward_a = 2'b10;
      else if (wb_valid && wb_reg_write && (wb_rd == ex_rs1))  forward_a = 2'b01;
    end
  end

  always_comb begin
    forward_b = 2'b00;
    if (ex_rs2 != '0) begin
      if (mem_valid && mem_reg_write && (mem_rd == ex_rs2))    forward_b = 2'b10;
      else if (wb_valid && wb_reg_write && (wb_rd == ex_rs2))  forward_b = 2'b01;
    end
  end
`else
  // Without forwarding, wait until the writer reaches WB; the regfile
  // writes before it reads, so WB itself never blocks.
  logic ex_writes;
  logic mem_writes;

  assign ex_writes  = ex_valid && ex_reg_write;
  assign mem_writes = mem_valid && mem_reg_write;
  assign hazard = (rs1_live && ((ex_writes  && (id_rs1 == ex_rd)) ||
                                (mem_writes && (id_rs1 == mem_rd)))) ||
                  (rs2_live && ((ex_writes  && (id_rs2 == ex_rd)) ||
                                (mem_writes && (id_rs2 == mem_rd))));

  assign forward_a = 2'b00;
  assign forward_b = 2'b00;
`endif

  // A flush kills the ID instruction anyway, so it must not also stall.
  assign stall   = id_valid && !ex_flush && hazard;
  assign load_id = id_valid && !ex_flush && !stall;

  // ---------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its source, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid        <= 1'b0;
      ex_ctrl         <= '0;
      ex_rs1          <= '0;
      ex_rs2          <= '0;
      ex_rd           <= '0;
      mem_valid       <= 1'b0;
      mem_mem_read    <= 1'b0;
      mem_mem_write   <= 1'b0;
      mem_reg_write   <= 1'b0;
      mem_wb_data_src <= 2'b00;
      mem_rd          <= '0;
      wb_valid        <= 1'b0;
      wb_reg_write    <= 1'b0;
      wb_wb_data_src  <= 2'b00;
      wb_rd           <= '0;
      stall_count     <= '0;
    end else begin
      // A bubble clears valid and controls but still captures the indices.
      ex_valid <= load_id;
      ex_ctrl  <= load_id ? id_ctrl : '0;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
      ex_rd    <= id_rd;

      // Later stages never freeze: the stall only holds the front end.
      mem_valid       <= ex_valid;
      mem_mem_read    <= ex_ctrl.mem_read;
      mem_mem_write   <= ex_ctrl.mem_write;
      mem_reg_write   <= ex_ctrl.reg_write;
      mem_wb_data_src <= ex_ctrl.wb_data_src;
      mem_rd          <= ex_rd;

      wb_valid       <= mem_valid;
      wb_reg_write   <= mem_reg_write;
      wb_wb_data_src <= mem_wb_data_src;
      wb_rd          <= mem_rd;

      if (stall && (stall_count != '1))
        stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

  assign ex_alu_src       = ex_ctrl.alu_src;
  assign ex_alu_op        = ex_ctrl.alu_op;
  assign ex_mem_read      = ex_ctrl.mem_read;
  assign ex_mem_write     = ex_ctrl.mem_write;
  assign ex_reg_write     = ex_ctrl.reg_write;
  assign ex_ctrl_transfer = ex_ctrl.ctrl_transfer;
  assign ex_wb_data_src   = ex_ctrl.wb_data_src;

endmodule

// File: tb/tb_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pipe -- self-checking bench for ctrl_pipe.
//
// A reference model keeps the three in-flight stages as a queue of decoded
// instruction records (front = EX, then MEM, then WB). Decode, hazard and
// forwarding expectations are computed from the instruction-set rules.
// Works for both builds; CTRL_FORWARD_EN selects the expected behaviour.
// ---------------------------------------------------------------------------
module tb_ctrl_pipe;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_MAX = '1;

  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] OPC_OPI  = 7'b0010011;
  localparam logic [6:0] OPC_LD   = 7'b0000011;
  localparam logic [6:0] OPC_ST   = 7'b0100011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_BAD  = 7'b1110011;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          id_valid = 1'b0;
  logic [6:0]    id_opcode = '0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic          ex_flush = 1'b0;
  logic          stall;
  logic          ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [1:0]    ex_alu_op, ex_ctrl_transfer, ex_wb_data_src;
  logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic          mem_valid, mem_mem_read, mem_mem_write, mem_reg_write;
  logic [1:0]    mem_wb_data_src;
  logic [AW-1:0] mem_rd;
  logic          wb_valid, wb_reg_write;
  logic [1:0]    wb_wb_data_src;
  logic [AW-1:0] wb_rd;
  logic [1:0]    forward_a, forward_b;
  logic [CW-1:0] stall_count;

  ctrl_pipe #(.REG_ADDR_W(AW), .STALL_CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_flush(ex_flush),
    .stall(stall),
    .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_alu_op(ex_alu_op), .ex_ctrl_transfer(ex_ctrl_transfer),
    .ex_wb_data_src(ex_wb_data_src), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_reg_write(mem_reg_write), .mem_wb_data_src(mem_wb_data_src), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_wb_data_src(wb_wb_data_src),
    .wb_rd(wb_rd), .forward_a(forward_a), .forward_b(forward_b),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // One instruction as it travels down the pipe.
  typedef struct packed {
    logic          valid;
    logic          alu_src;
    logic [1:0]    alu_op;
    logic          mem_read;
    logic          mem_write;
    logic          reg_write;
    logic [1:0]    xfer;
    logic [1:0]    wb_src;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
  } rec_t;

  rec_t        pipe[$];
  int unsigned stall_total;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Per-step samples: model expectation (e_*) and DUT observation (s_*).
  logic       e_stall, s_stall;
  logic [1:0] e_fa, e_fb, s_fa, s_fb;

  // ------------------------------------------------------------- model ---
  function automatic rec_t decode(logic [6:0] op, logic [AW-1:0] r1, r2, rd);
    rec_t r;
    bit op_r = (op == OPC_OP), opi = (op == OPC_OPI), ld = (op == OPC_LD);
    bit st = (op == OPC_ST), br = (op == OPC_BR), jal = (op == OPC_JAL);
    bit jalr = (op == OPC_JALR), lui = (op == OPC_LUI);
    r = '0;
    r.valid     = 1'b1;
    r.alu_src   = ld | st | opi | jalr | lui;
    r.alu_op    = (op_r | opi) ? 2'b01 : br ? 2'b10 : lui ? 2'b11 : 2'b00;
    r.mem_read  = ld;
    r.mem_write = st;
    r.reg_write = (op_r | opi | ld | jal | jalr | lui) && (rd != 0);
    r.xfer      = br ? 2'b01 : jal ? 2'b10 : jalr ? 2'b11 : 2'b00;
    r.wb_src    = ld ? 2'b01 : (jal | jalr) ? 2'b10 : lui ? 2'b11 : 2'b00;
    r.rs1 = r1; r.rs2 = r2; r.rd = rd;
    return r;
  endfunction

  function automatic bit reads_rs1(logic [6:0] op);
    return op inside {OPC_OP, OPC_OPI, OPC_LD, OPC_ST, OPC_BR, OPC_JALR};
  endfunction

  function automatic bit reads_rs2(logic [6:0] op);
    return op inside {OPC_OP, OPC_ST, OPC_BR};
  endfunction

  // Does record p produce a value that ID source r1/r2 needs?
  function automatic bit depends(rec_t p, logic [6:0] op, logic [AW-1:0] r1, r2);
    return (reads_rs1(op) && r1 != 0 && r1 == p.rd) ||
           (reads_rs2(op) && r2 != 0 && r2 == p.rd);
  endfunction

  function automatic logic model_stall(logic v, logic [6:0] op,
                                       logic [AW-1:0] r1, r2, logic fl);
    bit h;
`ifdef CTRL_FORWARD_EN
    h = pipe[0].valid && pipe[0].mem_read && depends(pipe[0], op, r1, r2);
`else
    h = 0;
    for (int k = 0; k < 2; k++)
      if (pipe[k].valid && pipe[k].reg_write && depends(pipe[k], op, r1, r2)) h = 1;
`endif
    return v && !fl && h;
  endfunction

  function automatic logic [1:0] model_fwd(logic [AW-1:0] src);
`ifdef CTRL_FORWARD_EN
    if (src != 0 && pipe[1].valid && pipe[1].reg_write && pipe[1].rd == src) return 2'b10;
    if (src != 0 && pipe[2].valid && pipe[2].reg_write && pipe[2].rd == src) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic logic [CW-1:0] model_count();
    return (stall_total >= int'(CNT_MAX)) ? CNT_MAX : CW'(stall_total);
  endfunction

  task automatic model_clear();
    pipe.delete();
    repeat (3) pipe.push_back('0);
    stall_total = 0;
  endtask

  // Drive one cycle of ID inputs, sample the combinational outputs, clock,
  // and advance the model. Returns #1 after the rising edge.
  task automatic step(input logic v, input logic [6:0] op,
                      input logic [AW-1:0] r1, r2, rd, input logic fl);
    rec_t entered;
    id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd; ex_flush = fl;
    #1;
    e_stall = model_stall(v, op, r1, r2, fl);
    e_fa    = model_fwd(pipe[0].rs1);
    e_fb    = model_fwd(pipe[0].rs2);
    s_stall = stall; s_fa = forward_a; s_fb = forward_b;
    @(posedge clk);
    if (reset) model_clear();
    else begin
      if (v && !e_stall && !fl) entered = decode(op, r1, r2, rd);
      else begin
        entered = '0; entered.rs1 = r1; entered.rs2 = r2; entered.rd = rd;
      end
      pipe.push_front(entered);
      void'(pipe.pop_back());
      if (e_stall) stall_total++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 7'd0, '0, '0, '0, 1'b0);
  endtask

  // ------------------------------------------------------------- tests ---
  task automatic test_reset();
    reset = 1'b1;
    model_clear();
    idle(3);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      n_cmp++;
      if ({s_stall, s_fa, s_fb} !== 5'b0) begin
        n_bad++; $display("FAIL reset_comb[%0d]: got %b want 0", i, {s_stall, s_fa, s_fb});
      end
      n_cmp++;
      if ({ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_alu_op,
           ex_ctrl_transfer, ex_wb_data_src, ex_rs1, ex_rs2, ex_rd, mem_valid,
           mem_mem_read, mem_mem_write, mem_reg_write, mem_wb_data_src, mem_rd,
           wb_valid, wb_reg_write, wb_wb_data_src, wb_rd} !== '0) begin
        n_bad++; $display("FAIL reset_regs[%0d]: pipeline registers not all zero", i);
      end
      n_cmp++;
      if (stall_count !== '0) begin
        n_bad++; $display("FAIL reset_count[%0d]: got %0d want 0", i, stall_count);
      end
    end
  endtask

  task automatic test_lui_op();
    step(1'b1, OPC_LUI, 5'd0, 5'd0, 5'd5, 1'b0);
    n_cmp++;
    if ({ex_valid, ex_alu_op, ex_wb_data_src, ex_alu_src} !== 6'b1_11_11_1) begin
      n_bad++; $display("FAIL lui_ex: got %b want 111111",
                        {ex_valid, ex_alu_op, ex_wb_data_src, ex_alu_src});
    end
    step(1'b1, OPC_OP, 5'd1, 5'd2, 5'd6, 1'b0);
    n_cmp++;
    if ({ex_alu_op, ex_wb_data_src, ex_reg_write} !== 5'b01_00_1) begin
      n_bad++; $display("FAIL op_ex: got %b want 01001", {ex_alu_op, ex_wb_data_src, ex_reg_write});
    end
    idle(1);
    n_cmp++;
    if ({wb_valid, wb_reg_write, wb_wb_data_src, wb_rd} !== {1'b1, 1'b1, 2'b11, 5'd5}) begin
      n_bad++; $display("FAIL lui_wb: got %b want 11_11_00101",
                        {wb_valid, wb_reg_write, wb_wb_data_src, wb_rd});
    end
    idle(3);
  endtask

  task automatic test_load_use();
    int n = 0;
`ifdef CTRL_FORWARD_EN
    int want_n = 1; logic [1:0] want_fa = 2'b01;
`else
    int want_n = 2; logic [1:0] want_fa = 2'b00;
`endif
    step(1'b1, OPC_LD, 5'd1, 5'd0, 5'd3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, OPC_OP, 5'd3, 5'd2, 5'd7, 1'b0);
      if (k == 0) begin
        n_cmp++;
        if ({s_stall, ex_valid} !== 2'b10) begin
          n_bad++; $display("FAIL lu_first: stall/ex_valid got %b want 10", {s_stall, ex_valid});
        end
      end
      if (s_stall !== 1'b1) break;
      n++;
    end
    n_cmp++;
    if (n != want_n) begin
      n_bad++; $display("FAIL lu_stall_cycles: got %0d want %0d", n, want_n);
    end
    idle(1);
    n_cmp++;
    if (s_fa !== want_fa) begin
      n_bad++; $display("FAIL lu_forward_a: got %b want %b", s_fa, want_fa);
    end
    n_cmp++;
    if (stall_count !== model_count()) begin
      n_bad++; $display("FAIL lu_count: got %0d want %0d", stall_count, model_count());
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    int n = 0;
`ifdef CTRL_FORWARD_EN
    int want_n = 0; logic [1:0] want_fb = 2'b10;
`else
    int want_n = 2; logic [1:0] want_fb = 2'b00;
`endif
    step(1'b1, OPC_OP, 5'd1, 5'd2, 5'd4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, OPC_OP, 5'd1, 5'd4, 5'd8, 1'b0);
      if (s_stall !== 1'b1) break;
      n++;
    end
    n_cmp++;
    if (n != want_n) begin
      n_bad++; $display("FAIL b2b_stall_cycles: got %0d want %0d", n, want_n);
    end
    idle(1);
    n_cmp++;
    if (s_fb !== want_fb) begin
      n_bad++; $display("FAIL b2b_forward_b: got %b want %b", s_fb, want_fb);
    end
    idle(3);
  endtask

  task automatic test_flush();
    step(1'b1, OPC_LD, 5'd1, 5'd0, 5'd3, 1'b0);
    step(1'b1, OPC_OP, 5'd3, 5'd2, 5'd7, 1'b1);
    n_cmp++;
    if (s_stall !== 1'b0) begin
      n_bad++; $display("FAIL flush_stall: got %b want 0", s_stall);
    end
    n_cmp++;
    if ({ex_valid, mem_valid, mem_mem_read, mem_rd} !== {1'b0, 1'b1, 1'b1, 5'd3}) begin
      n_bad++; $display("FAIL flush_regs: got %b want 011_00011",
                        {ex_valid, mem_valid, mem_mem_read, mem_rd});
    end
    idle(3);
  endtask

  task automatic test_x0();
    step(1'b1, OPC_OP, 5'd1, 5'd2, 5'd0, 1'b0);
    step(1'b1, OPC_OP, 5'd0, 5'd0, 5'd9, 1'b0);
    n_cmp++;
    if (s_stall !== 1'b0) begin
      n_bad++; $display("FAIL x0_stall: got %b want 0", s_stall);
    end
    idle(1);
    n_cmp++;
    if (s_fa !== 2'b00) begin
      n_bad++; $display("FAIL x0_forward_a: got %b want 00", s_fa);
    end
    n_cmp++;
    if ({wb_valid, wb_reg_write, wb_rd} !== {1'b1, 1'b0, 5'd0}) begin
      n_bad++; $display("FAIL x0_wb: got %b want 10_00000", {wb_valid, wb_reg_write, wb_rd});
    end
    idle(3);
  endtask

  task automatic test_stall_saturate();
    int n = 0;
    for (int i = 0; i < (1 << CW) + 2; i++) begin
      step(1'b1, OPC_LD, 5'd1, 5'd0, 5'd3, 1'b0);
      step(1'b1, OPC_OP, 5'd3, 5'd2, 5'd7, 1'b0);
      if (s_stall === 1'b1) n++;
    end
    n_cmp++;
    if (n != (1 << CW) + 2) begin
      n_bad++; $display("FAIL sat_stalls: got %0d want %0d", n, (1 << CW) + 2);
    end
    n_cmp++;
    if (stall_count !== CNT_MAX) begin
      n_bad++; $display("FAIL sat_count: got %0d want %0d", stall_count, CNT_MAX);
    end
    idle(3);
  endtask

  task automatic test_random();
    logic [6:0] tab [9] = '{OPC_OP, OPC_OPI, OPC_LD, OPC_ST, OPC_BR,
                            OPC_JAL, OPC_JALR, OPC_LUI, OPC_BAD};
    rec_t a;
    for (int i = 0; i < 400; i++) begin
      logic [6:0] op = tab[$urandom_range(8)];
      logic [AW-1:0] r1 = AW'($urandom_range(3));
      logic [AW-1:0] r2 = AW'($urandom_range(3));
      logic [AW-1:0] rd = AW'($urandom_range(3));
      if (op == OPC_BAD) begin r1 = '0; r2 = '0; end
      reset = ($urandom_range(99) < 2);
      step($urandom_range(9) < 8, op, r1, r2, rd, $urandom_range(9) == 0);
      reset = 1'b0;
      n_cmp++;
      if ({s_stall, s_fa, s_fb} !== {e_stall, e_fa, e_fb}) begin
        n_bad++; $display("FAIL rnd_comb[%0d]: stall/fa/fb got %b want %b",
                          i, {s_stall, s_fa, s_fb}, {e_stall, e_fa, e_fb});
      end
      a = {ex_valid, ex_alu_src, ex_alu_op, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_ctrl_transfer, ex_wb_data_src, ex_rs1, ex_rs2, ex_rd};
      n_cmp++;
      if (a !== pipe[0]) begin
        n_bad++; $display("FAIL rnd_ex[%0d]: got %h want %h", i, a, pipe[0]);
      end
      n_cmp++;
      if ({mem_valid, mem_mem_read, mem_mem_write, mem_reg_write, mem_wb_data_src, mem_rd} !==
          {pipe[1].valid, pipe[1].mem_read, pipe[1].mem_write, pipe[1].reg_write,
           pipe[1].wb_src, pipe[1].rd}) begin
        n_bad++; $display("FAIL rnd_mem[%0d]: got %b want %b", i,
          {mem_valid, mem_mem_read, mem_mem_write, mem_reg_write, mem_wb_data_src, mem_rd},
          {pipe[1].valid, pipe[1].mem_read, pipe[1].mem_write, pipe[1].reg_write,
           pipe[1].wb_src, pipe[1].rd});
      end
      n_cmp++;
      if ({wb_valid, wb_reg_write, wb_wb_data_src, wb_rd} !==
          {pipe[2].valid, pipe[2].reg_write, pipe[2].wb_src, pipe[2].rd}) begin
        n_bad++; $display("FAIL rnd_wb[%0d]: got %b want %b", i,
          {wb_valid, wb_reg_write, wb_wb_data_src, wb_rd},
          {pipe[2].valid, pipe[2].reg_write, pipe[2].wb_src, pipe[2].rd});
      end
      n_cmp++;
      if (stall_count !== model_count()) begin
        n_bad++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, stall_count, model_count());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lui_op();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_x0();
    test_stall_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
